// File: rtl/tcb_lib_arbiter_if.sv
// rtl/tcb_lib_arbiter_if.sv - TCB request/response types and the tcb_if bus interface
package tcb_lib_arbiter_pkg;

    typedef struct packed {
        logic        cmd;
        logic        wen;
        logic        ndn;
        logic [31:0] adr;
        logic [1:0]  siz;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [31:0] rdt;
        logic        sts;
    } tcb_rsp_t;

endpackage

interface tcb_if (
    input logic clk,
    input logic rst
);
    import tcb_lib_arbiter_pkg::*;

    logic     vld;
    logic     rdy;
    tcb_req_t req;
    tcb_rsp_t rsp;

    modport man (input clk, input rst, output vld, output req, input rdy, input rsp);
    modport sub (input clk, input rst, input vld, input req, output rdy, output rsp);

endinterface

// File: rtl/tcb_lib_arbiter.sv
// rtl/tcb_lib_arbiter.sv - IFN-to-1 TCB arbiter with stall lock and DLY-deep response routing
// TCB_LIB_ARBITER_ROUND_ROBIN_EN selects round-robin; undefined gives fixed lowest-index priority.
module tcb_lib_arbiter
    import tcb_lib_arbiter_pkg::*;
#(
    parameter int unsigned IFN = 2,
    parameter int unsigned DLY = 1,
    parameter int unsigned IDW = $clog2(IFN)
) (
    input  logic           clk,
    input  logic           rst,
    tcb_if.sub             sub [IFN-1:0],
    tcb_if.man             man,
    output logic [IFN-1:0] gnt
);

    logic [IFN-1:0] vld;
    logic [IFN-1:0] rdy;
    tcb_req_t       req [IFN];
    tcb_rsp_t       rsp [IFN];
    logic           vld_any;
    logic           trn;
    logic           lock;
    logic [IDW-1:0] lix;
    logic [IDW-1:0] win;
    logic [IDW-1:0] sel;
    logic           rsp_v;
    logic [IDW-1:0] rsp_idx;

    for (genvar i = 0; i < IFN; i++) begin : g_port
        assign vld[i]     = sub[i].vld;
        assign req[i]     = sub[i].req;
        assign sub[i].rdy = rdy[i];
        assign sub[i].rsp = rsp[i];
    end

    assign vld_any = |vld;
    assign trn     = vld_any & man.rdy;
    assign man.vld = vld_any;

`ifdef TCB_LIB_ARBITER_ROUND_ROBIN_EN
    logic [IDW-1:0] ptr;

    // Walk distances from farthest to nearest so the port right after ptr wins.
    always_comb begin
        win = ptr;
        for (int k = IFN; k >= 1; k--) begin
            for (int i = 0; i < IFN; i++) begin
                if (vld[i] && (i == (int'(ptr) + k) % IFN)) begin
                    win = IDW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(IFN - 1);
        end else if (trn) begin
            ptr <= sel;
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = IFN - 1; i >= 0; i--) begin
            if (vld[i]) begin
                win = IDW'(i);
            end
        end
    end
`endif

    assign sel = lock ? lix : win;

    always_comb begin
        gnt     = '0;
        rdy     = '0;
        man.req = req[0];
        for (int i = 0; i < IFN; i++) begin
            if (sel == IDW'(i)) begin
                gnt[i]  = vld_any;
                rdy[i]  = vld[i] & man.rdy;
                man.req = req[i];
            end
        end
    end

    // A stalled request keeps its grant until it transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock <= 1'b0;
            lix  <= '0;
        end else if (trn) begin
            lock <= 1'b0;
        end else if (vld_any) begin
            lock <= 1'b1;
            lix  <= sel;
        end
    end

    if (DLY > 0) begin : g_pipe
        logic [DLY-1:0] pv;
        logic [IDW-1:0] pidx [DLY];

        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
                for (int k = 0; k < DLY; k++) begin
                    pidx[k] <= '0;
                end
            end else begin
                pv[0]   <= trn;
                pidx[0] <= sel;
                for (int k = 1; k < DLY; k++) begin
                    pv[k]   <= pv[k-1];
                    pidx[k] <= pidx[k-1];
                end
            end
        end

        // Responses arriving while rst is high belong to dropped transfers.
        assign rsp_v   = pv[DLY-1] & ~rst;
        assign rsp_idx = pidx[DLY-1];
    end else begin : g_nopipe
        assign rsp_v   = trn & ~rst;
        assign rsp_idx = sel;
    end

    always_comb begin
        for (int i = 0; i < IFN; i++) begin
            rsp[i] = (rsp_v && (rsp_idx == IDW'(i))) ? man.rsp : '0;
        end
    end

endmodule

// File: tb/tb_tcb_lib_arbiter.sv
// tb/tb_tcb_lib_arbiter.sv - bench for tcb_lib_arbiter, DLY=1 and DLY=0 instances against a port-level model
module tb_tcb_lib_arbiter;
    import tcb_lib_arbiter_pkg::*;

    localparam int IFN = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [IFN-1:0] s_vld;
    tcb_req_t       s_req [IFN];
    logic           m_rdy;
    tcb_rsp_t       m_rsp;

    logic [IFN-1:0] gnt1, gnt0, rdy1, rdy0;
    tcb_rsp_t       rsp1 [IFN];
    tcb_rsp_t       rsp0 [IFN];

    tcb_if s1_if [IFN-1:0] (.clk(clk), .rst(rst));
    tcb_if s0_if [IFN-1:0] (.clk(clk), .rst(rst));
    tcb_if man1_if (.clk(clk), .rst(rst));
    tcb_if man0_if (.clk(clk), .rst(rst));

    for (genvar i = 0; i < IFN; i++) begin : g_drv
        assign s1_if[i].vld = s_vld[i];
        assign s1_if[i].req = s_req[i];
        assign s0_if[i].vld = s_vld[i];
        assign s0_if[i].req = s_req[i];
        assign rdy1[i]      = s1_if[i].rdy;
        assign rsp1[i]      = s1_if[i].rsp;
        assign rdy0[i]      = s0_if[i].rdy;
        assign rsp0[i]      = s0_if[i].rsp;
    end

    assign man1_if.rdy = m_rdy;
    assign man1_if.rsp = m_rsp;
    assign man0_if.rdy = m_rdy;
    assign man0_if.rsp = m_rsp;

    tcb_lib_arbiter #(.IFN(IFN), .DLY(1)) dut (
        .clk(clk), .rst(rst), .sub(s1_if), .man(man1_if), .gnt(gnt1)
    );

    tcb_lib_arbiter #(.IFN(IFN), .DLY(0)) dut0 (
        .clk(clk), .rst(rst), .sub(s0_if), .man(man0_if), .gnt(gnt0)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference state: lock flag/owner, last served port, port owed a response next cycle.
    int m_lock = 0;
    int m_lix  = 0;
    int m_ptr  = IFN - 1;
    int m_pend = -1;
    logic [IFN-1:0] last_vld = '0;
    logic [IFN-1:0] last_rdy = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic tcb_req_t rand_req();
        tcb_req_t r;
        r.cmd = 1'($urandom);
        r.wen = 1'($urandom);
        r.ndn = 1'($urandom);
        r.adr = $urandom;
        r.siz = 2'($urandom);
        r.ben = 4'($urandom);
        r.wdt = $urandom;
        return r;
    endfunction

    function automatic int model_grant();
        if (m_lock != 0) return m_lix;
`ifdef TCB_LIB_ARBITER_ROUND_ROBIN_EN
        for (int k = 1; k <= IFN; k++) begin
            if (s_vld[(m_ptr + k) % IFN]) return (m_ptr + k) % IFN;
        end
`else
        for (int i = 0; i < IFN; i++) begin
            if (s_vld[i]) return i;
        end
`endif
        return 0;
    endfunction

    task automatic check_model();
        int             g;
        bit             any;
        bit             trn;
        int             own1;
        int             own0;
        logic [IFN-1:0] exp_gnt;
        logic [IFN-1:0] exp_rdy;
        tcb_rsp_t       exp_rsp;
        any     = |s_vld;
        g       = model_grant();
        trn     = any && m_rdy;
        exp_gnt = any ? (3'(1) << g) : '0;
        exp_rdy = (s_vld[g] && m_rdy) ? (3'(1) << g) : '0;
        own1    = rst ? -1 : m_pend;
        own0    = (rst || !trn) ? -1 : g;
        chk("gnt", gnt1, exp_gnt);
        chk("gnt_dly0", gnt0, exp_gnt);
        chk("man_vld", man1_if.vld, any);
        if (any) chk("man_req", man1_if.req, s_req[g]);
        chk("sub_rdy", rdy1, exp_rdy);
        chk("sub_rdy_dly0", rdy0, exp_rdy);
        for (int i = 0; i < IFN; i++) begin
            exp_rsp = (i == own1) ? m_rsp : '0;
            chk($sformatf("rsp[%0d]", i), rsp1[i], exp_rsp);
            exp_rsp = (i == own0) ? m_rsp : '0;
            chk($sformatf("rsp_dly0[%0d]", i), rsp0[i], exp_rsp);
        end
        if (rst) begin
            m_lock = 0;
            m_lix  = 0;
            m_ptr  = IFN - 1;
            m_pend = -1;
        end else begin
            m_pend = trn ? g : -1;
            if (trn) begin
                m_lock = 0;
                m_ptr  = g;
            end else if (any) begin
                m_lock = 1;
                m_lix  = g;
            end
        end
        last_vld = s_vld;
        last_rdy = exp_rdy;
    endtask

    task automatic cycle();
        m_rsp = {$urandom, 1'($urandom)};
        @(negedge clk);
        check_model();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IFN-1:0] exp_g;
        s_vld = '0;
        m_rdy = 1'b0;
        m_rsp = '0;
        for (int i = 0; i < IFN; i++) s_req[i] = rand_req();

        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // All ports requesting, downstream always ready
        s_vld = 3'b111;
        m_rdy = 1'b1;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < IFN; i++) s_req[i] = rand_req();
            m_rsp = {$urandom, 1'($urandom)};
`ifdef TCB_LIB_ARBITER_ROUND_ROBIN_EN
            exp_g = 3'(1) << (n % 3);
`else
            exp_g = 3'b001;
`endif
            @(negedge clk);
            chk("rr_seq", gnt1, exp_g);
            check_model();
            @(posedge clk);
            #1;
        end
        s_vld = '0;
        cycle();

        // Single write on port 1
        s_vld        = 3'b010;
        s_req[1]     = rand_req();
        s_req[1].cmd = 1'b1;
        s_req[1].wen = 1'b1;
        s_req[1].adr = 32'h10;
        s_req[1].wdt = 32'hA5A5A5A5;
        m_rsp        = {$urandom, 1'($urandom)};
        @(negedge clk);
        chk("single_gnt", gnt1, 3'b010);
        chk("single_adr", man1_if.req.adr, 32'h10);
        check_model();
        @(posedge clk);
        #1;
        s_vld = '0;
        cycle();

        // Stall on port 2; port 0 joins mid-stall
        s_vld    = 3'b100;
        s_req[2] = rand_req();
        s_req[0] = rand_req();
        m_rdy    = 1'b0;
        cycle();
        s_vld = 3'b101;
        cycle();
        cycle();
        m_rdy = 1'b1;
        m_rsp = {$urandom, 1'($urandom)};
        @(negedge clk);
        chk("stall_gnt", gnt1, 3'b100);
        chk("stall_rdy", rdy1, 3'b100);
        check_model();
        @(posedge clk);
        #1;
        s_vld = 3'b001;
        m_rsp = {$urandom, 1'($urandom)};
        @(negedge clk);
        chk("after_stall_gnt", gnt1, 3'b001);
        check_model();
        @(posedge clk);
        #1;

        // Reset right after a port 1 read transfer
        s_vld        = 3'b010;
        s_req[1]     = rand_req();
        s_req[1].cmd = 1'b0;
        s_req[1].wen = 1'b0;
        cycle();
        s_vld = '0;
        rst   = 1'b1;
        m_rsp = {32'hDEADBEEF, 1'b1};
        @(negedge clk);
        chk("rst_drop_rsp1", rsp1[1], 33'h0);
        check_model();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        s_vld = 3'b111;
        m_rsp = {$urandom, 1'($urandom)};
        @(negedge clk);
        chk("post_rst_gnt", gnt1, 3'b001);
        check_model();
        @(posedge clk);
        #1;
        s_vld = '0;
        cycle();

        // Same-cycle response on the DLY=0 instance
        s_vld        = 3'b100;
        s_req[2]     = rand_req();
        s_req[2].wen = 1'b0;
        m_rsp        = {32'h12345678, 1'b0};
        @(negedge clk);
        chk("dly0_rdt", rsp0[2].rdt, 32'h12345678);
        check_model();
        @(posedge clk);
        #1;
        s_vld = '0;
        cycle();

        // Random traffic; a port left stalled keeps vld and req unchanged
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < IFN; i++) begin
                if (!(last_vld[i] && !last_rdy[i])) begin
                    s_vld[i] = 1'($urandom_range(0, 1));
                    s_req[i] = rand_req();
                end
            end
            m_rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
